// File: rtl/loteria_pkg.sv
// Shared constants and types for the lottery entry stage and game FSM.
package loteria_pkg;

    localparam int unsigned MAX_DIGITS = 5;
    localparam int unsigned MAX_DIGIT  = 9;
    localparam int unsigned COUNT_W    = 3;

    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [3:0]         digit_t;

    // True when the switch value is a single decimal digit.
    function automatic logic is_bcd(input digit_t d);
        return d <= digit_t'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser, counter-based debouncer and press (1->0) detector
// for one active-low push-button.
module debounce
    import loteria_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic press_event
);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // flush_q[1] marks that sync_q[1] now reflects the pin rather than reset.
    logic [1:0]       flush_q;
    logic             armed_q, armed_d;

    // State registers; reset treats the button as released and disarmed.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= 2'b11;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            cnt_q        <= '0;
            flush_q      <= 2'b00;
            armed_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], raw_n};
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            flush_q      <= {flush_q[0], 1'b1};
            armed_q      <= armed_d;
        end
    end

    // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // A key held across reset must be seen released before it may fire.
        armed_d = armed_q | (flush_q[1] & sync_q[1]);
    end

    assign press_event = armed_q & stable_dly_q & ~stable_q;

endmodule

// File: rtl/loteria_entrada.sv
// Input conditioning for the lottery game: debounced insert/finish pulses,
// validated BCD digit and the five-digit entry protocol.
module loteria_entrada
    import loteria_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_insert_n,
    input  logic       key_finish_n,
    input  logic [3:0] sw_num,
    output logic [3:0] num_out,
    output logic       insert_pulse,
    output logic       finish_pulse,
    output logic [2:0] digit_count,
    output logic       err
);

    logic   insert_event, finish_event;
    digit_t sw_meta_q, sw_sync_q;
    digit_t num_q, num_d;
    logic   ins_q, ins_d;
    logic   fin_q, fin_d;
    count_t cnt_q, cnt_d;
    logic   err_q, err_d;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_insert (
        .clk        (clk),
        .reset      (reset),
        .raw_n      (key_insert_n),
        .press_event(insert_event)
    );

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_finish (
        .clk        (clk),
        .reset      (reset),
        .raw_n      (key_finish_n),
        .press_event(finish_event)
    );

    // Switch synchroniser and output/round registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            num_q     <= '0;
            ins_q     <= 1'b0;
            fin_q     <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            sw_meta_q <= sw_num;
            sw_sync_q <= sw_meta_q;
            num_q     <= num_d;
            ins_q     <= ins_d;
            fin_q     <= fin_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Entry protocol; an insert in the same cycle as a finish wins and the finish is lost.
    always_comb begin
        num_d = num_q;
        ins_d = 1'b0;
        fin_d = 1'b0;
        cnt_d = cnt_q;
        err_d = err_q;
        if (insert_event) begin
            if (cnt_q == count_t'(MAX_DIGITS)) begin
                cnt_d = cnt_q;
            end else if (!is_bcd(sw_sync_q)) begin
                err_d = 1'b1;
            end else begin
                num_d = sw_sync_q;
                ins_d = 1'b1;
                cnt_d = cnt_q + count_t'(1);
                err_d = 1'b0;
            end
        end else if (finish_event && (cnt_q == count_t'(MAX_DIGITS))) begin
            fin_d = 1'b1;
            cnt_d = '0;
        end
    end

    assign num_out      = num_q;
    assign insert_pulse = ins_q;
    assign finish_pulse = fin_q;
    assign digit_count  = cnt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_loteria_entrada.sv
// Self-checking bench for loteria_entrada with DEBOUNCE_CYCLES = 4.
module tb_loteria_entrada;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_insert_n = 1'b1;
    logic       key_finish_n = 1'b1;
    logic [3:0] sw_num = 4'd0;
    logic [3:0] num_out;
    logic       insert_pulse;
    logic       finish_pulse;
    logic [2:0] digit_count;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int n_ins = 0;
    int n_fin = 0;
    bit chk_en = 1'b0;

    loteria_entrada #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_insert_n(key_insert_n),
        .key_finish_n(key_finish_n),
        .sw_num      (sw_num),
        .num_out     (num_out),
        .insert_pulse(insert_pulse),
        .finish_pulse(finish_pulse),
        .digit_count (digit_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Key level as seen by the design at edge n is the pin sampled at edge n-2.
    int         m_edge;
    bit         m_p1 [2];
    bit         m_p2 [2];
    bit         m_stable [2];
    bit         m_fell [2];
    int         m_run [2];
    int         m_rel [2];
    bit         m_raw [2];
    logic [3:0] m_sw1, m_sw2;
    logic [3:0] e_num;
    bit         e_ins, e_fin, e_err;
    int         e_cnt;

    always @(posedge clk) begin
        m_raw[0] = key_insert_n;
        m_raw[1] = key_finish_n;
        if (reset) begin
            m_edge = 0;
            for (int k = 0; k < 2; k++) begin
                m_p1[k] = 1'b1; m_p2[k] = 1'b1; m_stable[k] = 1'b1;
                m_fell[k] = 1'b0; m_run[k] = 0; m_rel[k] = 1 << 30;
            end
            m_sw1 = 4'd0; m_sw2 = 4'd0;
            e_num = 4'd0; e_ins = 1'b0; e_fin = 1'b0; e_err = 1'b0; e_cnt = 0;
        end else begin
            m_edge++;
            e_ins = 1'b0;
            e_fin = 1'b0;
            if (m_fell[0]) begin
                if (e_cnt == 5) begin
                    e_cnt = 5;
                end else if (m_sw2 > 4'd9) begin
                    e_err = 1'b1;
                end else begin
                    e_num = m_sw2; e_ins = 1'b1; e_cnt++; e_err = 1'b0;
                end
            end else if (m_fell[1] && e_cnt == 5) begin
                e_fin = 1'b1;
                e_cnt = 0;
            end
            for (int k = 0; k < 2; k++) begin
                m_fell[k] = 1'b0;
                if (m_p2[k] == m_stable[k]) begin
                    m_run[k] = 0;
                end else begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_stable[k] = !m_stable[k];
                        m_run[k] = 0;
                        // Press counts only if the pin was seen high after reset.
                        if (!m_stable[k] && m_rel[k] <= m_edge - 2) m_fell[k] = 1'b1;
                    end
                end
                if (m_raw[k] && m_rel[k] > m_edge) m_rel[k] = m_edge;
                m_p2[k] = m_p1[k];
                m_p1[k] = m_raw[k];
            end
            m_sw2 = m_sw1;
            m_sw1 = sw_num;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("num_out", 32'(num_out), 32'(e_num));
            check("insert_pulse", 32'(insert_pulse), 32'(e_ins));
            check("finish_pulse", 32'(finish_pulse), 32'(e_fin));
            check("digit_count", 32'(digit_count), 32'(e_cnt));
            check("err", 32'(err), 32'(e_err));
            n_ins += int'(insert_pulse);
            n_fin += int'(finish_pulse);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic enter(input logic [3:0] v);
        sw_num = v;
        tick(3);
        key_insert_n = 1'b0;
        tick(8);
        key_insert_n = 1'b1;
        tick(8);
    endtask

    task automatic press_finish();
        key_finish_n = 1'b0;
        tick(8);
        key_finish_n = 1'b1;
        tick(8);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_num"}, 32'(num_out), 32'd0);
        check({tag, "_ins"}, 32'(insert_pulse), 32'd0);
        check({tag, "_fin"}, 32'(finish_pulse), 32'd0);
        check({tag, "_cnt"}, 32'(digit_count), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_i, base_f, r, hold;

        // Reset state and clean-press latency.
        tick(1);
        do_reset();
        check_zero("reset");
        tick(5);
        sw_num = 4'd5;
        tick(3);
        key_insert_n = 1'b0;
        tick(6);
        check("lat_edge5", 32'(insert_pulse), 32'd0);
        tick(1);
        check("lat_edge6", 32'(insert_pulse), 32'd1);
        check("lat_num", 32'(num_out), 32'd5);
        check("lat_cnt", 32'(digit_count), 32'd1);
        check("lat_err", 32'(err), 32'd0);
        tick(1);
        check("lat_edge7", 32'(insert_pulse), 32'd0);
        tick(4);
        key_insert_n = 1'b1;
        tick(10);

        // Bounce then settle: one pulse.
        base_i = n_ins;
        for (int i = 0; i < 10; i++) begin
            key_insert_n = (i % 2 == 1);
            tick(2);
        end
        key_insert_n = 1'b0;
        tick(12);
        key_insert_n = 1'b1;
        tick(12);
        check("bounce_pulses", 32'(n_ins - base_i), 32'd1);
        check("bounce_cnt", 32'(digit_count), 32'd2);

        // Short glitch: no pulse.
        base_i = n_ins;
        key_insert_n = 1'b0;
        tick(3);
        key_insert_n = 1'b1;
        tick(12);
        check("glitch_pulses", 32'(n_ins - base_i), 32'd0);

        // Finish with a partial round is ignored.
        base_f = n_fin;
        press_finish();
        check("early_finish", 32'(n_fin - base_f), 32'd0);
        check("early_finish_cnt", 32'(digit_count), 32'd2);

        // Non-BCD switch value sets err, then a valid digit clears it.
        base_i = n_ins;
        enter(4'd12);
        check("nonbcd_pulses", 32'(n_ins - base_i), 32'd0);
        check("nonbcd_err", 32'(err), 32'd1);
        check("nonbcd_cnt", 32'(digit_count), 32'd2);
        check("nonbcd_num", 32'(num_out), 32'd5);
        enter(4'd0);
        check("zero_num", 32'(num_out), 32'd0);
        check("zero_err", 32'(err), 32'd0);
        check("zero_cnt", 32'(digit_count), 32'd3);

        // Full round, sixth digit ignored, then finish.
        do_reset();
        enter(4'd5); enter(4'd0); enter(4'd9); enter(4'd6); enter(4'd7);
        check("full_num", 32'(num_out), 32'd7);
        check("full_cnt", 32'(digit_count), 32'd5);
        base_i = n_ins;
        enter(4'd3);
        check("sixth_pulses", 32'(n_ins - base_i), 32'd0);
        check("sixth_num", 32'(num_out), 32'd7);
        check("sixth_cnt", 32'(digit_count), 32'd5);
        base_f = n_fin;
        press_finish();
        check("finish_pulses", 32'(n_fin - base_f), 32'd1);
        check("finish_cnt", 32'(digit_count), 32'd0);

        // Simultaneous insert and finish at count 4.
        enter(4'd1); enter(4'd2); enter(4'd3); enter(4'd4);
        base_i = n_ins;
        base_f = n_fin;
        sw_num = 4'd8;
        tick(3);
        key_insert_n = 1'b0;
        key_finish_n = 1'b0;
        tick(8);
        key_insert_n = 1'b1;
        key_finish_n = 1'b1;
        tick(8);
        check("both_ins", 32'(n_ins - base_i), 32'd1);
        check("both_fin", 32'(n_fin - base_f), 32'd0);
        check("both_cnt", 32'(digit_count), 32'd5);
        check("both_num", 32'(num_out), 32'd8);
        press_finish();
        check("both_after_fin", 32'(digit_count), 32'd0);

        // Reset mid-round with insert held across reset release.
        enter(4'd1); enter(4'd2); enter(4'd3);
        sw_num = 4'd2;
        tick(3);
        key_insert_n = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        check_zero("midreset");
        base_i = n_ins;
        tick(20);
        check("held_pulses", 32'(n_ins - base_i), 32'd0);
        key_insert_n = 1'b1;
        tick(10);
        key_insert_n = 1'b0;
        tick(8);
        key_insert_n = 1'b1;
        tick(8);
        check("repress_pulses", 32'(n_ins - base_i), 32'd1);
        check("repress_cnt", 32'(digit_count), 32'd1);
        check("repress_num", 32'(num_out), 32'd2);

        // Randomised traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 10);
            sw_num = 4'($urandom_range(0, 15));
            tick(3);
            hold = $urandom_range(1, 12);
            if (r <= 5) begin
                key_insert_n = 1'b0;
                tick(hold);
            end else if (r <= 7) begin
                key_finish_n = 1'b0;
                tick(hold);
            end else if (r == 8) begin
                key_insert_n = 1'b0;
                key_finish_n = 1'b0;
                tick(hold);
            end else if (r == 9) begin
                for (int j = 0; j < 12; j++) begin
                    key_insert_n = 1'($urandom_range(0, 1));
                    key_finish_n = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    reset = 1'b1;
                    tick(2);
                    reset = 1'b0;
                end
            end
            key_insert_n = 1'b1;
            key_finish_n = 1'b1;
            tick($urandom_range(8, 14));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/loteria_entrada.md
# loteria_entrada

Input-conditioning stage that sits directly upstream of the lottery game FSM. It turns raw DE2 push-buttons (active-low KEY) and the 4-bit number switches into clean, single-cycle `insert` / `finish` pulses plus a validated BCD digit. It also enforces the game's entry protocol: exactly five digits, then finish.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a key level change (1 ms at 50 MHz); minimum 2.
- `CNT_W`, default 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `key_insert_n`  in  1  raw insert button, active-low, asynchronous.
- `key_finish_n`  in  1  raw finish button, active-low, asynchronous.
- `sw_num`  in  4  raw number switches, asynchronous.
- `num_out`  out  4  last accepted digit (0–9); feeds FSM `num`.
- `insert_pulse`  out  1  one-cycle pulse per accepted digit; feeds FSM `insert`.
- `finish_pulse`  out  1  one-cycle pulse per accepted finish; feeds FSM `finish`.
- `digit_count`  out  3  digits accepted in the current round (0–5).
- `err`  out  1  sticky flag: the last insert attempt carried a non-BCD value.

## Operation
- Synchronisers: 2-flop chain on each key and on every `sw_num` bit. On reset, key chains load 1 (released) and the switch chain loads 0.
- Debounce, per key:
  - `stable` register (reset 1) and counter (reset 0).
  - Synced level == `stable`: clear the counter.
  - Otherwise increment. When the counter would reach `DEBOUNCE_CYCLES`, toggle `stable` and clear the counter.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no change.
- Press event: `stable` goes 1→0. Release produces no event.
- Insert event:
  - synced `sw_num` ≤ 9 and `digit_count` < 5: `num_out` ← synced `sw_num`, `insert_pulse` = 1 for one cycle, `digit_count` += 1, `err` ← 0.
  - synced `sw_num` > 9: no pulse, `num_out` and `digit_count` unchanged, `err` ← 1.
  - `digit_count` == 5: ignored, with no change to any output.
- Finish event:
  - `digit_count` == 5: `finish_pulse` = 1 for one cycle, `digit_count` ← 0.
  - `digit_count` < 5: ignored.
- Insert and finish events in the same cycle: insert is processed and finish is dropped. A dropped finish needs a fresh press.
- Holding a key produces exactly one event; a new event requires release followed by press.
- Round state: IDLE (count 0) → DIG1..DIG4 → FULL (count 5) → finish → IDLE. Only `reset` returns a partial round to IDLE.

## Timing
- Reset values: `num_out`=0, `insert_pulse`=0, `finish_pulse`=0, `digit_count`=0, `err`=0. All sync, stable and counter state is re-initialised.
- Reset asserted mid-debounce or mid-round aborts everything. A key still held after reset release must first be seen released before it can produce an event.
- Latency for a clean press, where edge 0 is the first edge sampling the low level:
  - `stable` falls at edge D+1 (D = `DEBOUNCE_CYCLES`).
  - `insert_pulse` / `finish_pulse` go high at edge D+2 and low at edge D+3.
- `num_out` updates on the same edge the pulse rises, and holds until the next accepted insert.
- Switches must be stable for at least 3 cycles before the pulse edge. They are not debounced.
- Pulses are registered outputs with no combinational path from inputs.

## Structure
- Shared package `loteria_pkg`: `MAX_DIGITS`=5, `MAX_DIGIT`=9, and digit-count width 3. The game FSM uses the same package.
- One sub-module: `debounce` (parameters `DEBOUNCE_CYCLES`, `CNT_W`; ports clk, reset, raw_n, press_event).
  - Contains the 2-flop sync, counter, `stable` and falling-edge detect.
  - Instantiated twice.
- Top level holds the switch synchroniser, round counter, validation and output registers.

## Test plan (D=4)
- Reset, clean press of insert with `sw_num`=5 held → `insert_pulse` high exactly one cycle at edge 6; `num_out`=5, `digit_count`=1, `err`=0.
- Insert key bouncing 0/1 every 2 cycles for 20 cycles, then settled low → exactly one `insert_pulse`. A 3-cycle low glitch alone → no pulse.
- Insert with `sw_num`=12 → no pulse, `err`=1, `digit_count` unchanged. Next insert with `sw_num`=0 → pulse, `num_out`=0, `err`=0.
- Enter 5,0,9,6,7; sixth insert with 3 → ignored, `num_out`=7, count stays 5. Finish → one `finish_pulse`, count=0.
- Finish pressed at count 2 → no pulse. Insert and finish events in the same cycle at count 4 → insert pulse only, count=5.
- Reset asserted at count 3 while insert is held → all outputs 0. Key held through reset release produces no pulse until a release and re-press.
